riscv_dmem_arbiter: RTL and testbench
=====================================

Name: riscv_dmem_arbiter

Overview:
- Two-requester arbiter that shares the riscv_core data-memory port (mem_d_*) between the core's data port (m0) and a second master (m1, DMA/debug).
- Sits between the requesters and the data memory/cache.
- Forwards one request per accept handshake and computes mem_d_cacheable_o from the cacheable address window.
- Routes in-order responses back to the issuing requester using an outstanding-ID FIFO.

Parameters:
MEM_CACHE_ADDR_MIN, 32'h80000000, inclusive lower bound of cacheable window
MEM_CACHE_ADDR_MAX, 32'h8fffffff, inclusive upper bound of cacheable window
OUTSTANDING, 4, max accepted-but-unacked requests (power of 2, >=2)
TIMEOUT_CYCLES, 256, ack watchdog limit (optional feature only)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous assert, active-low (0 = reset)
mN_addr_i  in  32  request address, N in {0,1}
mN_data_wr_i  in  32  write data
mN_rd_i  in  1  read request
mN_wr_i  in  4  byte write strobes
mN_req_tag_i  in  11  request tag
mN_invalidate_i / mN_writeback_i / mN_flush_i  in  1  cache maintenance ops
mN_accept_o  out  1  request N taken this cycle
mN_ack_o  out  1  response for requester N
mN_error_o  out  1  response error
mN_data_rd_o  out  32  read data (valid with mN_ack_o)
mN_resp_tag_o  out  11  response tag
mem_d_addr_o, mem_d_data_wr_o, mem_d_rd_o, mem_d_wr_o, mem_d_req_tag_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o  out  32/32/1/4/11/1/1/1  forwarded request
mem_d_cacheable_o  out  1  MEM_CACHE_ADDR_MIN <= mem_d_addr_o <= MEM_CACHE_ADDR_MAX
mem_d_accept_i, mem_d_ack_i, mem_d_error_i  in  1  downstream handshake and response
mem_d_data_rd_i  in  32  downstream read data
mem_d_resp_tag_i  in  11  downstream response tag
spurious_ack_o  out  1  one-cycle pulse: ack arrived with FIFO empty

Behaviour:
- Request valid: reqN = mN_rd_i | (|mN_wr_i) | mN_invalidate_i | mN_writeback_i | mN_flush_i.
- Requesters hold all request fields stable until mN_accept_o is seen.
- States:
  - IDLE: no grant.
  - LOCK: grant latched to the requester presented while mem_d_accept_i = 0.
  - LOCK persists until that request is accepted; no preemption while locked.
- Arbitration in IDLE is round-robin:
  - rr pointer selects the preferred requester when both are valid.
  - After each accepted handshake, the pointer moves to the other requester.
  - A single valid requester is granted regardless of the pointer.
- Forwarding is combinational, with zero-cycle request latency: the granted requester's fields drive mem_d_*. With no grant, all mem_d_* outputs are 0.
- Full (count == OUTSTANDING):
  - mem_d_rd_o, mem_d_wr_o and the maintenance ops are forced to 0.
  - mN_accept_o = 0.
  - The grant lock is held.
  - The full check uses the registered count, so an ack in the same cycle does not admit a push; the push happens next cycle.
- Accept: mN_accept_o = grantN & ~full & mem_d_accept_i. On accept, the requester ID is pushed into the FIFO and count increments.
- Response:
  - On mem_d_ack_i, the FIFO head ID routes ack, error, data and tag combinationally (zero-cycle) to that requester only; the other requester's ack = 0.
  - The head entry is popped on the ack.
  - A push and a pop in the same cycle leave count unchanged.
- Ack with FIFO empty: the ack is dropped, spurious_ack_o pulses for 1 cycle, and no mN_ack_o is asserted.
- Counters: FIFO pointers wrap modulo OUTSTANDING; count width is clog2(OUTSTANDING)+1.
- Reset values: state IDLE, rr pointer = m0, count/pointers 0, spurious_ack_o 0. All mN_accept_o/mN_ack_o/mN_error_o = 0.
- Reset mid-operation: outstanding entries are discarded. Acks arriving after reset count as spurious.

Optional Feature:
- Macro: RISCV_DMEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter runs while count > 0 and no ack arrives; it clears on each ack.
  - At TIMEOUT_CYCLES, the arbiter synthesizes ack+error to the head requester, with resp_tag 0 and data 0, and pops the head entry.
  - A sticky timeout_o output (1 bit) sets and clears only on reset.
- Without the macro: no counter and no timeout_o port; the arbiter waits indefinitely.

Test Plan:
- Only m0 writes 0xA5A5A5A5 to 0x80000004, wr = 4'b1111, mem_d_accept_i = 1 -> same cycle m0_accept_o = 1, mem_d_cacheable_o = 1. A later ack -> m0_ack_o = 1, m1_ack_o = 0.
- m1 reads 0x7FFFFFFC -> mem_d_cacheable_o = 0. Ack with data 0x5A5A5A5A -> m1_data_rd_o = 0x5A5A5A5A with m1_ack_o.
- Both requesters valid every cycle with continuous accept -> grants alternate m0, m1, m0, m1. Acks return in order to the matching requester.
- mem_d_accept_i = 0 for 3 cycles while m1 is granted, then m0 raises its request -> grant stays m1 until accept.
- 4 accepts without ack -> 5th request is blocked (mem_d_rd_o = 0). Ack and request in the same cycle -> accept occurs on the next cycle. Ack with empty FIFO -> spurious_ack_o pulses once.
- rst_i low with 2 requests outstanding -> count = 0, all acks/accepts 0. (Timeout build) no ack for 256 cycles -> m0_ack_o & m0_error_o, timeout_o = 1.

Source files
------------

// File: rtl/riscv_dmem_arbiter_if.sv
// riscv_dmem_arbiter_if: request/response bundle for one data-memory port
interface riscv_dmem_arbiter_if;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        rd;
    logic [3:0]  wr;
    logic [10:0] req_tag;
    logic        invalidate;
    logic        writeback;
    logic        flush;
    logic        accept;
    logic        ack;
    logic        error;
    logic [31:0] data_rd;
    logic [10:0] resp_tag;
    modport master (
        output addr, data_wr, rd, wr, req_tag, invalidate, writeback, flush,
        input  accept, ack, error, data_rd, resp_tag
    );
    modport slave (
        input  addr, data_wr, rd, wr, req_tag, invalidate, writeback, flush,
        output accept, ack, error, data_rd, resp_tag
    );
endinterface

// File: rtl/riscv_dmem_arbiter.sv
// riscv_dmem_arbiter: round-robin sharing of the core data-memory port between m0 and m1.
// Define RISCV_DMEM_ARB_TIMEOUT_EN to add the ack watchdog and the timeout_o port.
module riscv_dmem_arbiter #(
    parameter logic [31:0] MEM_CACHE_ADDR_MIN = 32'h80000000,
    parameter logic [31:0] MEM_CACHE_ADDR_MAX = 32'h8fffffff,
    parameter int          OUTSTANDING        = 4
`ifdef RISCV_DMEM_ARB_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES     = 256
`endif
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    riscv_dmem_arbiter_if.slave         m0,
    riscv_dmem_arbiter_if.slave         m1,
    riscv_dmem_arbiter_if.master        mem_d,
    output logic                        mem_d_cacheable_o,
    output logic                        spurious_ack_o
`ifdef RISCV_DMEM_ARB_TIMEOUT_EN
    ,
    output logic                        timeout_o
`endif
);
    localparam int PW = $clog2(OUTSTANDING);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_rr, r_lock_id, r_spurious;
    logic [PW:0]            r_count;
    logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [OUTSTANDING-1:0] r_fifo;
    logic                   w_req0, w_req1, w_gnt_valid, w_gnt_id;
    logic                   w_full, w_empty, w_accept, w_ack, w_head, w_to;

    assign w_req0 = m0.rd | (|m0.wr) | m0.invalidate | m0.writeback | m0.flush;
    assign w_req1 = m1.rd | (|m1.wr) | m1.invalidate | m1.writeback | m1.flush;
    assign w_full  = r_count == (PW+1)'(OUTSTANDING);
    assign w_empty = r_count == '0;

    // A locked grant ignores the round-robin pointer until its request is taken.
    assign w_gnt_valid = (r_state == LOCK) ? (r_lock_id ? w_req1 : w_req0) : (w_req0 | w_req1);
    assign w_gnt_id    = (r_state == LOCK) ? r_lock_id : ((w_req0 & w_req1) ? r_rr : w_req1);
    assign w_accept    = rst_i & w_gnt_valid & ~w_full & mem_d.accept;

    assign m0.accept = w_accept & ~w_gnt_id;
    assign m1.accept = w_accept & w_gnt_id;

    always_comb begin
        w_state_nxt      = IDLE;
        mem_d.addr       = '0;
        mem_d.data_wr    = '0;
        mem_d.req_tag    = '0;
        mem_d.rd         = 1'b0;
        mem_d.wr         = '0;
        mem_d.invalidate = 1'b0;
        mem_d.writeback  = 1'b0;
        mem_d.flush      = 1'b0;
        if (w_gnt_valid && !w_accept)
            w_state_nxt = LOCK;
        if (w_gnt_valid) begin
            mem_d.addr       = w_gnt_id ? m1.addr : m0.addr;
            mem_d.data_wr    = w_gnt_id ? m1.data_wr : m0.data_wr;
            mem_d.req_tag    = w_gnt_id ? m1.req_tag : m0.req_tag;
            mem_d.rd         = ~w_full & (w_gnt_id ? m1.rd : m0.rd);
            mem_d.wr         = w_full ? 4'b0 : (w_gnt_id ? m1.wr : m0.wr);
            mem_d.invalidate = ~w_full & (w_gnt_id ? m1.invalidate : m0.invalidate);
            mem_d.writeback  = ~w_full & (w_gnt_id ? m1.writeback : m0.writeback);
            mem_d.flush      = ~w_full & (w_gnt_id ? m1.flush : m0.flush);
        end
    end

    assign mem_d_cacheable_o = (mem_d.addr >= MEM_CACHE_ADDR_MIN) && (mem_d.addr <= MEM_CACHE_ADDR_MAX);

    // Responses come back in order, so the FIFO head names their owner.
    assign w_head = r_fifo[r_rd_ptr];
    assign w_ack  = rst_i & ((mem_d.ack & ~w_empty) | w_to);

    assign m0.ack      = w_ack & ~w_head;
    assign m1.ack      = w_ack & w_head;
    assign m0.error    = m0.ack & (mem_d.error | w_to);
    assign m1.error    = m1.ack & (mem_d.error | w_to);
    assign m0.data_rd  = (m0.ack & ~w_to) ? mem_d.data_rd : '0;
    assign m1.data_rd  = (m1.ack & ~w_to) ? mem_d.data_rd : '0;
    assign m0.resp_tag = (m0.ack & ~w_to) ? mem_d.resp_tag : '0;
    assign m1.resp_tag = (m1.ack & ~w_to) ? mem_d.resp_tag : '0;

    assign spurious_ack_o = r_spurious;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rr       <= 1'b0;
            r_lock_id  <= 1'b0;
            r_spurious <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo     <= '0;
        end else begin
            r_lock_id  <= w_gnt_id;
            r_spurious <= mem_d.ack & w_empty;
            r_count    <= r_count + {{PW{1'b0}}, w_accept} - {{PW{1'b0}}, w_ack};
            if (w_accept) begin
                r_rr             <= ~w_gnt_id;
                r_fifo[r_wr_ptr] <= w_gnt_id;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_ack)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

`ifdef RISCV_DMEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_wdog;
    logic          r_timeout;

    // A real ack always wins over the watchdog in the same cycle.
    assign w_to      = rst_i & ~w_empty & ~mem_d.ack & (r_wdog == TW'(TIMEOUT_CYCLES));
    assign timeout_o = r_timeout;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wdog <= (w_empty | mem_d.ack | w_to) ? '0 : r_wdog + 1'b1;
            if (w_to)
                r_timeout <= 1'b1;
        end
    end
`else
    assign w_to = 1'b0;
`endif
endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// tb_riscv_dmem_arbiter: directed and random traffic against a queue-based reference model.
module tb_riscv_dmem_arbiter;
    localparam logic [31:0] CMIN = 32'h80000000;
    localparam logic [31:0] CMAX = 32'h8fffffff;
    localparam int          OUTS = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic cacheable, spurious;
`ifdef RISCV_DMEM_ARB_TIMEOUT_EN
    logic timeout;
`endif

    riscv_dmem_arbiter_if bus0();
    riscv_dmem_arbiter_if bus1();
    riscv_dmem_arbiter_if memb();

    riscv_dmem_arbiter dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .m0                (bus0),
        .m1                (bus1),
        .mem_d             (memb),
        .mem_d_cacheable_o (cacheable),
`ifdef RISCV_DMEM_ARB_TIMEOUT_EN
        .timeout_o         (timeout),
`endif
        .spurious_ack_o    (spurious)
    );

    always #5 clk_i = ~clk_i;

    int   n_chk = 0;
    int   n_pass = 0;
    bit   q_route[$];
    int   m_out = 0;
    bit   m_rr = 0, m_locked = 0, m_lock_id = 0;
    bit   pend = 0, pend_id = 0;
    bit   exp_spur = 0;
    logic [1:0] acc_seen = '0;
    bit   busy [2];
    logic [31:0] addr_tab [6] = '{32'h7fffffff, 32'h80000000, 32'h8fffffff,
                                  32'h90000000, 32'h80000004, 32'h7ffffffc};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // Request-side reference: who should win, what mem_d should show, and what gets queued.
    always @(negedge clk_i) begin : pred
        bit r0, r1, gv, g, full, acc, pop, rd, inv, wb, fl;
        logic [31:0] a, d;
        logic [10:0] t;
        logic [3:0]  w;
        if (!rst_i) begin
            chk("rst_accept", {bus0.accept, bus1.accept}, 2'b00);
            m_out = 0; m_rr = 0; m_locked = 0; pend = 0;
        end else begin
            r0 = bus0.rd | (|bus0.wr) | bus0.invalidate | bus0.writeback | bus0.flush;
            r1 = bus1.rd | (|bus1.wr) | bus1.invalidate | bus1.writeback | bus1.flush;
            if (m_locked) begin g = m_lock_id; gv = g ? r1 : r0; end
            else begin gv = r0 | r1; g = (r0 && r1) ? m_rr : r1; end
            full = (m_out == OUTS);
            acc  = gv && !full && memb.accept;
            a = !gv ? 32'h0 : (g ? bus1.addr : bus0.addr);
            d = !gv ? 32'h0 : (g ? bus1.data_wr : bus0.data_wr);
            t = !gv ? 11'h0 : (g ? bus1.req_tag : bus0.req_tag);
            rd  = gv && !full && (g ? bus1.rd : bus0.rd);
            w   = (gv && !full) ? (g ? bus1.wr : bus0.wr) : 4'h0;
            inv = gv && !full && (g ? bus1.invalidate : bus0.invalidate);
            wb  = gv && !full && (g ? bus1.writeback : bus0.writeback);
            fl  = gv && !full && (g ? bus1.flush : bus0.flush);
            chk("req",
                {bus0.accept, bus1.accept, memb.rd, memb.wr, memb.invalidate, memb.writeback,
                 memb.flush, cacheable, memb.addr, memb.data_wr, memb.req_tag},
                {acc && !g, acc && g, rd, w, inv, wb, fl, (a >= CMIN && a <= CMAX), a, d, t});
            pop   = memb.ack && m_out > 0;
            m_out = m_out + int'(acc) - int'(pop);
            if (acc) begin m_rr = !g; pend = 1; pend_id = g; end
            m_locked  = gv && !acc;
            m_lock_id = g;
        end
    end

    always @(posedge clk_i) begin
        if (pend) begin q_route.push_back(pend_id); pend = 0; end
    end

    // Response monitor: pops the expected owner whenever a response shows up.
    always @(negedge clk_i) begin : mon
        bit id;
        logic [127:0] e;
        if (!rst_i) begin
            q_route.delete();
            exp_spur = 0;
            chk("rst_resp", {bus0.ack, bus1.ack, spurious}, 3'b000);
        end else begin
            if (spurious || exp_spur) chk("spurious", spurious, exp_spur);
            exp_spur = 0;
            if (memb.ack || bus0.ack || bus1.ack) begin
                e = '0;
                if (memb.ack && q_route.size() > 0) begin
                    id = q_route.pop_front();
                    e = id ? {1'b0, 1'b1, 1'b0, memb.error, 32'h0, memb.data_rd, 11'h0, memb.resp_tag}
                           : {1'b1, 1'b0, memb.error, 1'b0, memb.data_rd, 32'h0, memb.resp_tag, 11'h0};
                end else if (memb.ack) exp_spur = 1;
                chk("resp", {bus0.ack, bus1.ack, bus0.error, bus1.error, bus0.data_rd, bus1.data_rd,
                             bus0.resp_tag, bus1.resp_tag}, e);
            end
        end
    end

    always @(negedge clk_i) acc_seen = {bus1.accept, bus0.accept};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input int n, input logic [31:0] a, input logic [31:0] d, input logic rd,
                       input logic [3:0] wr, input logic [2:0] mt, input logic [10:0] t);
        if (n == 0) begin
            bus0.addr = a; bus0.data_wr = d; bus0.rd = rd; bus0.wr = wr; bus0.req_tag = t;
            {bus0.invalidate, bus0.writeback, bus0.flush} = mt;
        end else begin
            bus1.addr = a; bus1.data_wr = d; bus1.rd = rd; bus1.wr = wr; bus1.req_tag = t;
            {bus1.invalidate, bus1.writeback, bus1.flush} = mt;
        end
    endtask

    task automatic drop(input int n);
        req(n, 32'h0, 32'h0, 1'b0, 4'h0, 3'b000, 11'h0);
    endtask

    task automatic mem_set(input logic acc, input logic ack, input logic [31:0] d,
                           input logic [10:0] t, input logic e);
        memb.accept = acc; memb.ack = ack; memb.data_rd = d; memb.resp_tag = t; memb.error = e;
    endtask

    task automatic rand_req(input int n);
        int op, ix;
        logic [31:0] a;
        ix = $urandom_range(0, 6);
        a  = (ix == 6) ? $urandom : addr_tab[ix];
        op = $urandom_range(0, 4);
        req(n, a, $urandom, op == 0, (op == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
            (op == 2) ? 3'b100 : (op == 3) ? 3'b010 : (op == 4) ? 3'b001 : 3'b000, 11'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && m_out > 0; i++) begin
            mem_set(1'b0, 1'b1, $urandom, 11'($urandom), 1'($urandom_range(0, 1)));
            tick();
        end
        mem_set(1'b0, 1'b0, 32'h0, 11'h0, 1'b0);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        drop(0);
        drop(1);
        mem_set(1'b0, 1'b0, 32'h0, 11'h0, 1'b0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        // Single m0 write into the cacheable window, then its ack.
        req(0, 32'h80000004, 32'hA5A5A5A5, 1'b0, 4'hF, 3'b000, 11'h012);
        mem_set(1'b1, 1'b0, 32'h0, 11'h0, 1'b0);
        tick();
        drop(0);
        mem_set(1'b0, 1'b1, 32'h11112222, 11'h012, 1'b0);
        tick();
        // m1 read just below the window.
        req(1, 32'h7FFFFFFC, 32'h0, 1'b1, 4'h0, 3'b000, 11'h345);
        mem_set(1'b1, 1'b0, 32'h0, 11'h0, 1'b0);
        tick();
        drop(1);
        mem_set(1'b0, 1'b1, 32'h5A5A5A5A, 11'h345, 1'b0);
        tick();
        // m1 stalls while the pointer favours m0; m0 arrives and must wait.
        req(1, 32'h80000100, 32'h0, 1'b1, 4'h0, 3'b000, 11'h101);
        mem_set(1'b0, 1'b0, 32'h0, 11'h0, 1'b0);
        repeat (3) tick();
        req(0, 32'h90000000, 32'h0, 1'b1, 4'h0, 3'b000, 11'h202);
        tick();
        mem_set(1'b1, 1'b0, 32'h0, 11'h0, 1'b0);
        tick();
        drop(1);
        tick();
        drop(0);
        drain();
        // Both requesters hammering with continuous accept and in-order acks.
        req(0, 32'h80000010, 32'hCAFE0000, 1'b0, 4'h3, 3'b000, 11'h0AA);
        req(1, 32'h80000020, 32'h0, 1'b1, 4'h0, 3'b000, 11'h155);
        mem_set(1'b1, 1'b0, 32'h0, 11'h0, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) begin
            mem_set(1'b1, 1'b1, $urandom, 11'($urandom), 1'($urandom_range(0, 1)));
            tick();
        end
        drop(0);
        drop(1);
        drain();
        // Fill to OUTSTANDING, stay blocked, then ack and request together.
        req(0, 32'h80001000, 32'h12345678, 1'b0, 4'hF, 3'b000, 11'h777);
        mem_set(1'b1, 1'b0, 32'h0, 11'h0, 1'b0);
        repeat (6) tick();
        mem_set(1'b1, 1'b1, 32'hDEADBEEF, 11'h7FF, 1'b1);
        tick();
        mem_set(1'b1, 1'b0, 32'h0, 11'h0, 1'b0);
        tick();
        drop(0);
        drain();
        mem_set(1'b0, 1'b1, 32'hFFFFFFFF, 11'h3FF, 1'b0);
        tick();
        mem_set(1'b0, 1'b0, 32'h0, 11'h0, 1'b0);
        tick();
        // Reset with two requests outstanding; a later ack is spurious.
        req(0, 32'h80000040, 32'h0, 1'b1, 4'h0, 3'b000, 11'h040);
        mem_set(1'b1, 1'b0, 32'h0, 11'h0, 1'b0);
        repeat (2) tick();
        rst_i = 1'b0;
        mem_set(1'b1, 1'b1, 32'h0BAD0BAD, 11'h001, 1'b0);
        repeat (2) tick();
        drop(0);
        mem_set(1'b0, 1'b0, 32'h0, 11'h0, 1'b0);
        rst_i = 1'b1;
        tick();
        mem_set(1'b0, 1'b1, 32'h0000FACE, 11'h002, 1'b0);
        tick();
        mem_set(1'b0, 1'b0, 32'h0, 11'h0, 1'b0);
        tick();
        // Random traffic; requesters hold fields until they see their accept.
        busy[0] = 0;
        busy[1] = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!busy[n] || acc_seen[n]) begin
                    if ($urandom_range(0, 2) != 0) begin rand_req(n); busy[n] = 1; end
                    else begin drop(n); busy[n] = 0; end
                end
            end
            mem_set($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom,
                    11'($urandom), $urandom_range(0, 7) == 0);
            tick();
        end
        drop(0);
        drop(1);
        drain();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
